// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add, logic, shift) complete in one state step. Multiply and
// divide iterate one radix-2 step per cycle over WIDTH cycles. Handles one
// operation at a time.
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   in_valid / in_ready     operand handshake (a, b, aluop)
//   out_valid / out_ready   result handshake (res_high, res_low)
//   a, b                    WIDTH-bit operands (shift amount = low log2(WIDTH) bits of b)
//   aluop                   4-bit operation select
//   res_high, res_low       2*WIDTH result, held stable while out_valid
module seq_alu #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_high,
    output logic [WIDTH-1:0] res_low
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    localparam logic [3:0] OpAddu = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpMulu = 4'd2;
    localparam logic [3:0] OpMul  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpDivu = 4'd7;
    localparam logic [3:0] OpDiv  = 4'd8;
    localparam logic [3:0] OpSll  = 4'd9;
    localparam logic [3:0] OpSrl  = 4'd10;
    localparam logic [3:0] OpSra  = 4'd11;
    localparam logic [3:0] OpAddl = 4'd12;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_q;   // negate quotient (div) or full product (mul)
    logic             r_neg_r;   // negate remainder (div only)
    logic [WIDTH-1:0] r_hi;      // mul: partial product high; div: partial remainder
    logic [WIDTH-1:0] r_lo;      // mul: multiplier / product low; div: dividend / quotient
    logic [WIDTH-1:0] r_opd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;

    // Single-cycle datapath, evaluated straight from the inputs at accept.
    logic [WIDTH:0]           w_sumu;
    logic [WIDTH:0]           w_sums;
    logic [SW-1:0]            w_sh;
    logic [2*WIDTH-1:0]       w_sll;
    logic [2*WIDTH-1:0]       w_srl;
    logic signed [2*WIDTH-1:0] w_sra_src;
    logic [2*WIDTH-1:0]       w_sra;
    logic [WIDTH-1:0]         w_hi;
    logic [WIDTH-1:0]         w_lo;

    // Iterative setup.
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Iterative step and final fixup.
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dtmp;
    logic               w_dge;
    logic [WIDTH-1:0]   w_ddiff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign in_ready  = reset_n && (r_state == StIdle);
    assign out_valid = r_out_valid;
    assign res_high  = r_res_hi;
    assign res_low   = r_res_lo;

    always_comb begin
        w_sumu    = {1'b0, a} + {1'b0, b};
        w_sums    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        w_sh      = b[SW-1:0];
        w_sll     = {{WIDTH{1'b0}}, a} << w_sh;
        // Right shifts of {a, 0}: upper word is the shifted value, lower word
        // collects the bits shifted out, left-aligned.
        w_srl     = {a, {WIDTH{1'b0}}} >> w_sh;
        w_sra_src = {a, {WIDTH{1'b0}}};
        w_sra     = w_sra_src >>> w_sh;
        w_hi      = '0;
        w_lo      = '0;
        case (aluop)
            OpAddu: begin
                w_hi = {{(WIDTH-1){1'b0}}, w_sumu[WIDTH]};
                w_lo = w_sumu[WIDTH-1:0];
            end
            OpAdd: begin
                w_hi = {WIDTH{w_sums[WIDTH]}};
                w_lo = w_sums[WIDTH-1:0];
            end
            OpAnd:  w_lo = a & b;
            OpOr:   w_lo = a | b;
            OpXor:  w_lo = a ^ b;
            OpSll: begin
                w_hi = w_sll[2*WIDTH-1:WIDTH];
                w_lo = w_sll[WIDTH-1:0];
            end
            OpSrl: begin
                w_hi = w_srl[WIDTH-1:0];
                w_lo = w_srl[2*WIDTH-1:WIDTH];
            end
            OpSra: begin
                w_hi = w_sra[WIDTH-1:0];
                w_lo = w_sra[2*WIDTH-1:WIDTH];
            end
            OpAddl: w_lo = w_sumu[WIDTH-1:0];
            default: begin
                w_hi = '0;
                w_lo = '0;
            end
        endcase
    end

    always_comb begin
        w_is_mul = (aluop == OpMulu) || (aluop == OpMul);
        w_is_div = DIV_EN && ((aluop == OpDivu) || (aluop == OpDiv));
        w_signed = (aluop == OpMul) || (aluop == OpDiv);
        // Magnitude of signed MIN is 2^(WIDTH-1), which still fits unsigned.
        w_mag_a  = (w_signed && a[WIDTH-1]) ? ('0 - a) : a;
        w_mag_b  = (w_signed && b[WIDTH-1]) ? ('0 - b) : b;
    end

    always_comb begin
        // Shift-add multiply: add multiplicand on multiplier LSB, shift right.
        w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
        // Restoring divide: shift next dividend bit into remainder, trial subtract.
        w_dtmp  = {r_hi, r_lo[WIDTH-1]};
        w_dge   = (w_dtmp >= {1'b0, r_opd});
        w_ddiff = w_dtmp[WIDTH-1:0] - r_opd;
        if (r_is_div) begin
            w_step_hi = w_dge ? w_ddiff : w_dtmp[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_dge};
        end else begin
            w_step_hi = w_madd[WIDTH:1];
            w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
        w_prod = {w_step_hi, w_step_lo};
        if (r_is_div) begin
            w_fin_hi = r_neg_r ? ('0 - w_step_hi) : w_step_hi;
            w_fin_lo = r_neg_q ? ('0 - w_step_lo) : w_step_lo;
        end else begin
            if (r_neg_q) begin
                w_prod = '0 - w_prod;
            end
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opd       <= '0;
            r_out_valid <= 1'b0;
            r_res_hi    <= '0;
            r_res_lo    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        if (w_is_mul || w_is_div) begin
                            r_state  <= StRun;
                            r_count  <= CW'(WIDTH);
                            r_is_div <= w_is_div;
                            r_hi     <= '0;
                            r_lo     <= w_is_div ? w_mag_a : w_mag_b;
                            r_opd    <= w_is_div ? w_mag_b : w_mag_a;
                            // Divide by zero keeps the all-ones quotient unsigned;
                            // the remainder sign fixup then returns a unchanged.
                            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1])
                                        && !(w_is_div && (b == '0));
                            r_neg_r  <= w_signed && a[WIDTH-1];
                        end else begin
                            r_state     <= StDone;
                            r_res_hi    <= w_hi;
                            r_res_lo    <= w_lo;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    r_count <= r_count - CW'(1);
                    r_hi    <= w_step_hi;
                    r_lo    <= w_step_lo;
                    if (r_count == CW'(1)) begin
                        r_state     <= StDone;
                        r_res_hi    <= w_fin_hi;
                        r_res_lo    <= w_fin_lo;
                        r_out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=32, DIV_EN=1).
// Each operation is applied through the handshake; latency, in_ready behaviour
// and both result words are checked against hand-computed values.
module tb_seq_alu;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_high;
    logic [31:0] res_low;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(
        .WIDTH (32),
        .DIV_EN(1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .aluop    (aluop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_high (res_high),
        .res_low  (res_low)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one op, measure latency (negedges after the accept edge), check result,
    // optionally hold out_ready low for 'hold' cycles while offering a new op.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input int exp_lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input int hold);
        int   lat;
        logic rdy_bad;
        logic bp_bad;
        @(negedge clock);
        chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        aluop    = op;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        aluop    = 4'($urandom);
        lat      = 0;
        rdy_bad  = 1'b0;
        do begin
            @(negedge clock);
            lat++;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
        end while (out_valid !== 1'b1 && lat < 200);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(rdy_bad), 64'(0));
        chk({tag, "_hi"}, 64'(res_high), 64'(ehi));
        chk({tag, "_lo"}, 64'(res_low), 64'(elo));
        if (hold > 0) begin
            bp_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                aluop    = 4'd12;
                a        = 32'h1;
                b        = 32'h1;
                @(negedge clock);
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_high !== ehi
                    || res_low !== elo) bp_bad = 1'b1;
            end
            in_valid = 1'b0;
            chk({tag, "_bp"}, 64'(bp_bad), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_drop"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic stray;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        aluop     = '0;
        repeat (3) @(negedge clock);
        chk("rst_ovalid", 64'(out_valid), 64'(0));
        chk("rst_res", {res_high, res_low}, 64'(0));
        chk("rst_irdy", 64'(in_ready), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_irdy", 64'(in_ready), 64'(1));

        // Add family
        do_op("addu",   4'd0, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 32'h0, 0);
        do_op("add",    4'd1, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h0, 0);
        do_op("add_pv", 4'd1, 32'h7FFFFFFF, 32'h1, 1, 32'h0, 32'h80000000, 0);
        do_op("add_nv", 4'd1, 32'h80000000, 32'h80000000, 1, 32'hFFFFFFFF, 32'h0, 0);
        do_op("addu_c", 4'd0, 32'h80000000, 32'h80000000, 1, 32'h1, 32'h0, 0);
        // Multiply
        do_op("mul",    4'd3, 32'hFFFFFFFD, 32'h5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        do_op("mulu",   4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h1, 0);
        do_op("mul_mm", 4'd3, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0, 0);
        // Divide
        do_op("divu",   4'd7, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);
        do_op("div",    4'd8, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_op("divu_0", 4'd7, 32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF, 0);
        do_op("div_0",  4'd8, 32'hFFFFFFFB, 32'd0, 33, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        do_op("div_ov", 4'd8, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 0);
        // Logic
        do_op("and", 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0, 32'hF000F000, 0);
        do_op("or",  4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0, 32'hFFF0FFF0, 0);
        do_op("xor", 4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0, 32'h0FF00FF0, 0);
        // Shifts
        do_op("sra",    4'd11, 32'h80000010, 32'd4,  1, 32'h0, 32'hF8000001, 0);
        do_op("sll",    4'd9,  32'hF0000001, 32'd4,  1, 32'hF, 32'h00000010, 0);
        do_op("sll_36", 4'd9,  32'hF0000001, 32'd36, 1, 32'hF, 32'h00000010, 0);
        do_op("srl",    4'd10, 32'h80000010, 32'd4,  1, 32'h0, 32'h08000001, 0);
        do_op("srl_out", 4'd10, 32'h0000000F, 32'd4, 1, 32'hF0000000, 32'h0, 0);
        do_op("sll_0",  4'd9,  32'h12345678, 32'd0,  1, 32'h0, 32'h12345678, 0);
        do_op("illegal", 4'd13, 32'h12345678, 32'h1, 1, 32'h0, 32'h0, 0);
        // Backpressure: result held for 10 cycles while another op is offered
        do_op("bp", 4'd3, 32'hFFFFFFFD, 32'h5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 10);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        chk("bp_ignored", 64'(stray), 64'(0));

        // Reset in cycle 10 of a MULU
        @(negedge clock);
        in_valid = 1'b1;
        aluop    = 4'd2;
        a        = 32'h12345678;
        b        = 32'h9ABCDEF0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mrst_ovalid", 64'(out_valid), 64'(0));
        chk("mrst_res", {res_high, res_low}, 64'(0));
        chk("mrst_irdy", 64'(in_ready), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);
        chk("mrst_rel", 64'(in_ready), 64'(1));
        stray = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        chk("mrst_noout", 64'(stray), 64'(0));
        do_op("addl", 4'd12, 32'd2, 32'd3, 1, 32'h0, 32'd5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
